// File: rtl/prbs_checker_if.sv
// prbs_checker_if: received-word stream into the PRBS checker.
// The checker is always ready, so the bundle is just a valid strobe plus data.
interface prbs_checker_if;
    logic        in_valid;
    logic [31:0] in_data;

    modport master (output in_valid, output in_data);
    modport slave  (input  in_valid, input  in_data);
endinterface

// File: rtl/prbs_checker.sv
// prbs_checker: self-synchronising checker for the 32-bit fetch-unit LFSR stream.
// Hunts for LOCK_COUNT consecutive recurrence matches, then tracks the stream
// with its own free-running expected word, counting mismatching words/bits.
// Optional feature macro: PRBS_CHK_ERRBITS_EN builds the mismatching-bit counter;
// without it err_bits is tied to zero.
module prbs_checker #(
    parameter int LOCK_COUNT = 4,
    parameter int LOSS_COUNT = 3,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    prbs_checker_if.slave        bus,
    input  logic                 clear_counts,
    output logic                 locked,
    output logic                 err_pulse,
    output logic [CNT_WIDTH-1:0] err_count,
    output logic [CNT_WIDTH-1:0] word_count,
    output logic [CNT_WIDTH-1:0] err_bits,
    output logic [31:0]          expected
);

    typedef enum logic [0:0] {SEARCH = 1'b0, LOCKED = 1'b1} state_t;

    localparam logic [3:0] LOCK_CNT = 4'(LOCK_COUNT);
    localparam logic [3:0] LOSS_CNT = 4'(LOSS_COUNT);

    // Generator recurrence: shift right, new MSB = XNOR of taps 31, 29, 28.
    function automatic logic [31:0] prbs_next(input logic [31:0] x);
        return {~(x[31] ^ x[29] ^ x[28]), x[31:1]};
    endfunction

    // Saturating add of a small amount to a counter.
    function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] x,
                                                     input logic [5:0] a);
        logic [CNT_WIDTH+5:0] s;
        s = {6'd0, x} + {{CNT_WIDTH{1'b0}}, a};
        if (s[CNT_WIDTH+5:CNT_WIDTH] != 6'd0) begin
            return {CNT_WIDTH{1'b1}};
        end else begin
            return s[CNT_WIDTH-1:0];
        end
    endfunction

`ifdef PRBS_CHK_ERRBITS_EN
    // Number of set bits in a 32-bit word.
    function automatic logic [5:0] popcount(input logic [31:0] v);
        logic [5:0] c;
        c = 6'd0;
        for (int i = 0; i < 32; i++) begin
            c = c + {5'd0, v[i]};
        end
        return c;
    endfunction
`endif

    state_t                state_r, state_nx;
    logic [31:0]           prev_r, prev_nx;
    logic                  have_prev_r, have_prev_nx;
    logic [3:0]            good_r, good_nx;
    logic [3:0]            bad_r, bad_nx;
    logic [31:0]           expected_r, expected_nx;
    logic                  err_pulse_r, err_pulse_nx;
    logic [CNT_WIDTH-1:0]  err_count_r, err_count_nx;
    logic [CNT_WIDTH-1:0]  word_count_r, word_count_nx;
`ifdef PRBS_CHK_ERRBITS_EN
    logic [CNT_WIDTH-1:0]  err_bits_r, err_bits_nx;
`endif

    // Next-state and next-output computation; idle beats hold everything.
    always_comb begin
        state_nx      = state_r;
        prev_nx       = prev_r;
        have_prev_nx  = have_prev_r;
        good_nx       = good_r;
        bad_nx        = bad_r;
        expected_nx   = expected_r;
        err_pulse_nx  = 1'b0;
        err_count_nx  = err_count_r;
        word_count_nx = word_count_r;
`ifdef PRBS_CHK_ERRBITS_EN
        err_bits_nx   = err_bits_r;
`endif
        if (bus.in_valid) begin
            case (state_r)
                SEARCH: begin
                    prev_nx      = bus.in_data;
                    have_prev_nx = 1'b1;
                    if (have_prev_r && (bus.in_data == prbs_next(prev_r))) begin
                        good_nx = good_r + 4'd1;
                    end else begin
                        good_nx = 4'd0;
                    end
                    if (good_nx == LOCK_CNT) begin
                        state_nx    = LOCKED;
                        expected_nx = prbs_next(bus.in_data);
                        bad_nx      = 4'd0;
                    end else begin
                        state_nx    = SEARCH;
                    end
                end
                LOCKED: begin
                    // Free-run the expected word so one bad word cannot corrupt the next.
                    expected_nx   = prbs_next(expected_r);
                    word_count_nx = sat_add(word_count_r, 6'd1);
                    if (bus.in_data != expected_r) begin
                        err_pulse_nx = 1'b1;
                        err_count_nx = sat_add(err_count_r, 6'd1);
                        bad_nx       = bad_r + 4'd1;
`ifdef PRBS_CHK_ERRBITS_EN
                        err_bits_nx  = sat_add(err_bits_r, popcount(bus.in_data ^ expected_r));
`endif
                        if (bad_nx == LOSS_CNT) begin
                            state_nx     = SEARCH;
                            good_nx      = 4'd0;
                            prev_nx      = bus.in_data;
                            have_prev_nx = 1'b1;
                        end else begin
                            state_nx     = LOCKED;
                        end
                    end else begin
                        bad_nx = 4'd0;
                    end
                end
                default: begin
                    state_nx = SEARCH;
                end
            endcase
        end else begin
            state_nx = state_r;
        end
    end

    // State and output registers; clear_counts overrides the counter updates.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r      <= SEARCH;
            prev_r       <= 32'd0;
            have_prev_r  <= 1'b0;
            good_r       <= 4'd0;
            bad_r        <= 4'd0;
            expected_r   <= 32'd0;
            err_pulse_r  <= 1'b0;
            err_count_r  <= {CNT_WIDTH{1'b0}};
            word_count_r <= {CNT_WIDTH{1'b0}};
        end else begin
            state_r      <= state_nx;
            prev_r       <= prev_nx;
            have_prev_r  <= have_prev_nx;
            good_r       <= good_nx;
            bad_r        <= bad_nx;
            expected_r   <= expected_nx;
            err_pulse_r  <= err_pulse_nx;
            if (clear_counts) begin
                err_count_r  <= {CNT_WIDTH{1'b0}};
                word_count_r <= {CNT_WIDTH{1'b0}};
            end else begin
                err_count_r  <= err_count_nx;
                word_count_r <= word_count_nx;
            end
        end
    end

`ifdef PRBS_CHK_ERRBITS_EN
    // Mismatching-bit counter, cleared together with the word counters.
    always_ff @(posedge clk) begin
        if (!rst) begin
            err_bits_r <= {CNT_WIDTH{1'b0}};
        end else if (clear_counts) begin
            err_bits_r <= {CNT_WIDTH{1'b0}};
        end else begin
            err_bits_r <= err_bits_nx;
        end
    end
    assign err_bits = err_bits_r;
`else
    assign err_bits = {CNT_WIDTH{1'b0}};
`endif

    assign locked     = (state_r == LOCKED);
    assign err_pulse  = err_pulse_r;
    assign err_count  = err_count_r;
    assign word_count = word_count_r;
    assign expected   = expected_r;

endmodule

// File: tb/tb_prbs_checker.sv
// tb_prbs_checker: directed self-checking bench for prbs_checker (default parameters).
module tb_prbs_checker;

    logic        clk;
    logic        rst;
    logic        clear_counts;
    logic        locked;
    logic        err_pulse;
    logic [15:0] err_count;
    logic [15:0] word_count;
    logic [15:0] err_bits;
    logic [31:0] expected;

    int n_cmp;
    int n_fail;
    logic [31:0] cur;

`ifdef PRBS_CHK_ERRBITS_EN
    localparam bit EB_EN = 1'b1;
`else
    localparam bit EB_EN = 1'b0;
`endif

    prbs_checker_if bus ();

    prbs_checker #(.LOCK_COUNT(4), .LOSS_COUNT(3), .CNT_WIDTH(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .clear_counts (clear_counts),
        .locked       (locked),
        .err_pulse    (err_pulse),
        .err_count    (err_count),
        .word_count   (word_count),
        .err_bits     (err_bits),
        .expected     (expected)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference recurrence of the generator.
    function automatic logic [31:0] lfsr_f(input logic [31:0] x);
        logic fb;
        fb = ~(x[31] ^ x[29] ^ x[28]);
        return {fb, x[31:1]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [31:0] w);
        bus.in_valid = 1'b1;
        bus.in_data  = w;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_data  = 32'h0;
    endtask

    task automatic send_clean();
        cur = lfsr_f(cur);
        send(cur);
    endtask

    task automatic send_bad(input logic [31:0] mask);
        cur = lfsr_f(cur);
        send(cur ^ mask);
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_locked"},   32'(locked),     32'd0);
        chk({tag, "_pulse"},    32'(err_pulse),  32'd0);
        chk({tag, "_errcnt"},   32'(err_count),  32'd0);
        chk({tag, "_wordcnt"},  32'(word_count), 32'd0);
        chk({tag, "_errbits"},  32'(err_bits),   32'd0);
        chk({tag, "_expected"}, expected,        32'd0);
    endtask

    initial begin
        n_cmp = 0;
        n_fail = 0;
        rst = 1'b0;
        clear_counts = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data = 32'h0;
        cur = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        check_reset("reset");

        // Clean stream from seed 1: lock after the 5th valid word.
        send(32'h00000001);
        send(32'h80000000);
        send(32'h40000000);
        send(32'hA0000000);
        chk("lock_before_5th", 32'(locked), 32'd0);
        send(32'hD0000000);
        chk("lock_at_5th", 32'(locked), 32'd1);
        chk("expected_after_lock", expected, 32'hE8000000);
        cur = 32'hD0000000;

        repeat (6) send_clean();
        chk("clean_wordcnt", 32'(word_count), 32'd6);
        chk("clean_errcnt", 32'(err_count), 32'd0);
        chk("clean_pulse", 32'(err_pulse), 32'd0);

        // Isolated single-bit error.
        send_bad(32'h00000001);
        chk("iso_pulse", 32'(err_pulse), 32'd1);
        chk("iso_errcnt", 32'(err_count), 32'd1);
        chk("iso_errbits", 32'(err_bits), EB_EN ? 32'd1 : 32'd0);
        chk("iso_locked", 32'(locked), 32'd1);
        chk("iso_wordcnt", 32'(word_count), 32'd7);
        send_clean();
        chk("post_iso_pulse", 32'(err_pulse), 32'd0);
        chk("post_iso_errcnt", 32'(err_count), 32'd1);
        chk("post_iso_expected", expected, lfsr_f(cur));
        send_clean();
        send_clean();
        chk("post_iso_wordcnt", 32'(word_count), 32'd10);

        // Three consecutive bad words lose lock.
        send_bad(32'h80000000);
        send_bad(32'h80000000);
        chk("loss_after_2", 32'(locked), 32'd1);
        send_bad(32'h80000000);
        chk("loss_after_3", 32'(locked), 32'd0);
        chk("loss_errcnt", 32'(err_count), 32'd4);
        chk("loss_wordcnt", 32'(word_count), 32'd13);

        // Relock: the first clean word fails the recurrence against the bad one.
        repeat (4) send_clean();
        chk("relock_pending", 32'(locked), 32'd0);
        chk("search_errcnt_hold", 32'(err_count), 32'd4);
        chk("search_wordcnt_hold", 32'(word_count), 32'd13);
        send_clean();
        chk("relock", 32'(locked), 32'd1);

        // Fifth error (4 bits), then reset mid-lock.
        send_bad(32'h000000F0);
        chk("fifth_errcnt", 32'(err_count), 32'd5);
        chk("fifth_errbits", 32'(err_bits), EB_EN ? 32'd8 : 32'd0);
        chk("fifth_wordcnt", 32'(word_count), 32'd14);
        pulse_reset();
        check_reset("midlock_reset");

        // Relock after reset needs 5 fresh valid words.
        send(32'h00000001);
        cur = 32'h00000001;
        repeat (3) send_clean();
        chk("post_rst_pending", 32'(locked), 32'd0);
        send_clean();
        chk("post_rst_lock", 32'(locked), 32'd1);

        // Constant input never locks.
        pulse_reset();
        for (int i = 0; i < 100; i++) begin
            send(32'hFFFFFFFF);
            chk("const_locked", 32'(locked), 32'd0);
        end
        chk("const_errcnt", 32'(err_count), 32'd0);
        chk("const_wordcnt", 32'(word_count), 32'd0);
        chk("const_errbits", 32'(err_bits), 32'd0);

        // Valid toggling: same lock point in valid beats, idle beats inert.
        send(32'h00000001);
        cur = 32'h00000001;
        idle();
        for (int i = 0; i < 3; i++) begin
            send_clean();
            idle();
            chk("toggle_pulse", 32'(err_pulse), 32'd0);
        end
        chk("toggle_pending", 32'(locked), 32'd0);
        send_clean();
        chk("toggle_lock", 32'(locked), 32'd1);
        idle();
        chk("toggle_idle_locked", 32'(locked), 32'd1);
        chk("toggle_idle_wordcnt", 32'(word_count), 32'd0);
        send_clean();
        idle();
        chk("toggle_wordcnt", 32'(word_count), 32'd1);
        chk("toggle_expected", expected, lfsr_f(cur));

        // clear_counts together with a mismatch.
        clear_counts = 1'b1;
        send_bad(32'h00000004);
        clear_counts = 1'b0;
        chk("clear_errcnt", 32'(err_count), 32'd0);
        chk("clear_wordcnt", 32'(word_count), 32'd0);
        chk("clear_errbits", 32'(err_bits), 32'd0);
        chk("clear_pulse", 32'(err_pulse), 32'd1);
        send_clean();
        chk("after_clear_wordcnt", 32'(word_count), 32'd1);
        chk("after_clear_pulse", 32'(err_pulse), 32'd0);
        chk("after_clear_locked", 32'(locked), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // Run-time bound.
    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/prbs_checker.md
# prbs_checker

Receive-side checker for the 32-bit pseudo-random word stream produced by the fetch-unit LFSR generator. It self-synchronises to the incoming stream, locks once a run of consecutive words obeys the generator recurrence, then counts mismatching words and flags loss of lock. It sits on the consumer end of any datapath carrying LFSR test traffic, including loopback and approximate-fetch stress paths, as a pass/fail monitor.

## Interface
Parameters:
- LOCK_COUNT, 4: consecutive recurrence matches required to enter LOCKED (1..15).
- LOSS_COUNT, 3: consecutive mismatches in LOCKED that force return to SEARCH (1..15).
- CNT_WIDTH, 16: width of err_count and word_count.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous, active-low reset (reset when rst==0 at a rising edge).
- in_valid  input  1  in_data carries a word this cycle; no back-pressure, the checker is always ready.
- in_data  input  32  received LFSR word.
- clear_counts  input  1  synchronously zero err_count, word_count and err_bits.
- locked  output  1  checker in LOCKED state.
- err_pulse  output  1  one-cycle strobe: the previous valid word mismatched while LOCKED.
- err_count  output  CNT_WIDTH  saturating count of mismatching words while LOCKED.
- word_count  output  CNT_WIDTH  saturating count of words checked while LOCKED.
- err_bits  output  CNT_WIDTH  saturating count of mismatching bits (see Configuration).
- expected  output  32  word expected at the next valid beat while LOCKED.

## Operation
- Recurrence F(x) = {~(x[31]^x[29]^x[28]), x[31:1]}: one right shift, new MSB is the XNOR of taps 31, 29, 28. F has no fixed point, so a constant input never locks.
- Internal state: prev (32), have_prev (1), good_run (4), bad_run (4), state in {SEARCH, LOCKED}.
- Only cycles with in_valid==1 change state; other cycles hold everything and err_pulse stays 0.
- SEARCH: if have_prev and in_data==F(prev), increment good_run, else clear it; prev<=in_data; have_prev<=1. When good_run reaches LOCK_COUNT, go to LOCKED, expected<=F(in_data), bad_run<=0. Counters do not change in SEARCH.
- LOCKED: compare in_data with expected; expected<=F(expected) regardless of the result, so isolated bit errors do not propagate. word_count++. On a match, bad_run<=0. On a mismatch: err_pulse next cycle, err_count++, bad_run++. If bad_run reaches LOSS_COUNT, go to SEARCH with good_run<=0, prev<=in_data, have_prev<=1.
- Counters saturate at all-ones and never wrap.
- clear_counts has priority over increments in the same cycle; that cycle's increment is dropped. It does not affect state, runs, or err_pulse.
- Reset (rst==0) at any time, mid-lock included, returns to SEARCH with have_prev=0 and all runs and counters at 0.

## Timing
- All outputs are registered. The word accepted at edge t is reflected in locked, err_pulse, counts and expected after edge t.
- Lock latency with a clean stream: LOCK_COUNT+1 valid words. The first word only seeds prev.
- Loss latency: LOSS_COUNT consecutive mismatching valid words. locked drops after the edge that accepts the last of them.
- Reset values: locked=0, err_pulse=0, err_count=0, word_count=0, err_bits=0, expected=0.

## Configuration
- PRBS_CHK_ERRBITS_EN defined: on each LOCKED mismatch, err_bits adds popcount(in_data ^ expected), saturating.
- Undefined: the popcount logic is not built and err_bits is tied to 0. All other behaviour is identical.

## Test plan
- Clean stream seeded 0x00000001 (words 0x00000001, 0x80000000, 0x40000000, 0xA0000000, ...), LOCK_COUNT=4 -> locked=1 after the 5th valid word; err_count=0 and word_count=N after N further words.
- While locked, flip bit 0 of one word -> a single err_pulse, err_count=1 (err_bits=1 if enabled), locked stays 1, and the next correct words match with no further errors.
- Three consecutive corrupted words (LOSS_COUNT=3) -> locked=0 after the 3rd. Resume the clean stream -> relock after 4 matching transitions.
- Constant input 0xFFFFFFFF for 100 valid beats -> locked stays 0 and all counts stay 0.
- in_valid toggling 1/0 on a clean stream -> same lock point in valid beats, with no change on idle cycles. Then clear_counts together with a mismatch -> err_count=0 next cycle.
- rst=0 for one edge while locked with err_count=5 -> all outputs at reset values next cycle, and relock needs 5 fresh valid words.
